// File: rtl/data_memory_arbiter.sv
// Purpose : shares the single data memory port between the CPU (requester 0)
//           and the auxiliary port streamer (requester 1). The CPU has fixed
//           priority, bounded by a starvation counter that forces an aux grant.
// Latency : grant is combinational (0 cycles); read data returns 1 cycle after
//           the grant, tagged by a registered per-requester rvalid.
// Backpressure: a requester holds req/we/addr/wdata stable until it sees its
//           gnt; a losing requester simply waits, and nothing is dropped.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU access request fields
//   cpu_gnt                  CPU access issued this cycle (combinational)
//   cpu_rvalid, cpu_rdata    CPU read return (rvalid registered)
//   aux_req/we/addr/wdata    aux streamer access request fields
//   aux_gnt                  aux access issued this cycle (combinational)
//   aux_rvalid, aux_rdata    aux read return (rvalid registered)
//   mem_read_en, mem_wr_en   data memory strobes
//   mem_addr, mem_wdata      data memory address / write data
//   mem_rdata                data memory read data, valid 1 cycle after read_en
//   owner                    registered last winner: 00 none, 01 CPU, 10 aux
module data_memory_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              mem_read_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam logic [2:0] LIMIT    = 3'(STARVE_LIMIT);
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_AUX  = 2'b10;

  // Consecutive CPU wins while aux was waiting; saturates at LIMIT.
  logic [2:0] starve_cnt;
  logic       cpu_win;
  logic       aux_win;

  // Grant decision. Reset suppresses every grant so requests are ignored.
  always_comb begin
    cpu_win = 1'b0;
    aux_win = 1'b0;
    if (!rst) begin
      if (aux_req && (starve_cnt == LIMIT)) begin
        aux_win = 1'b1;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end else if (aux_req) begin
        aux_win = 1'b1;
      end
    end
  end

  assign cpu_gnt = cpu_win;
  assign aux_gnt = aux_win;

  // Memory port mux; idle port drives all zeros.
  always_comb begin
    mem_read_en = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (cpu_win) begin
      mem_read_en = ~cpu_we;
      mem_wr_en   = cpu_we;
      mem_addr    = cpu_addr;
      mem_wdata   = cpu_wdata;
    end else if (aux_win) begin
      mem_read_en = ~aux_we;
      mem_wr_en   = aux_we;
      mem_addr    = aux_addr;
      mem_wdata   = aux_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 3'd0;
      cpu_rvalid <= 1'b0;
      aux_rvalid <= 1'b0;
      owner      <= OWN_NONE;
    end else begin
      // Counter only runs while aux is actually waiting behind the CPU.
      if (!aux_req || aux_win) begin
        starve_cnt <= 3'd0;
      end else if (cpu_win && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 3'd1;
      end

      cpu_rvalid <= cpu_win & ~cpu_we;
      aux_rvalid <= aux_win & ~aux_we;

      if (cpu_win) begin
        owner <= OWN_CPU;
      end else if (aux_win) begin
        owner <= OWN_AUX;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  // Memory data is broadcast; the rvalids say whose it is.
  assign cpu_rdata = mem_rdata;
  assign aux_rdata = mem_rdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Purpose : directed self-checking bench for data_memory_arbiter with a
//           scoreboard queue of expected read returns and owner values.
// Ports   : none (top-level bench); drives every DUT port.
module tb_data_memory_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, aux_req, aux_we;
  logic [9:0] cpu_addr, aux_addr;
  logic [7:0] cpu_wdata, aux_wdata;
  logic       cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid;
  logic [7:0] cpu_rdata, aux_rdata;
  logic       mem_read_en, mem_wr_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [1:0] owner;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       cv;
    logic       av;
    logic [7:0] d;
    logic [1:0] own;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(10), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_read_en(mem_read_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  // Memory contents as seen by a read: offset XOR 0x50 (0x3F5 -> 0xA5).
  function automatic logic [7:0] rd_fn(input logic [9:0] a);
    return a[7:0] ^ 8'h50;
  endfunction

  // 1-cycle read latency memory model.
  always @(posedge clk) mem_rdata <= rd_fn(mem_addr);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the return of the previous cycle, check this
  // cycle's grants and memory drive, queue the expected return, then clock.
  task automatic tick(input logic ec, input logic ea, input logic rst_at_edge);
    exp_t e;
    exp_t n;
    logic [9:0] ea_addr;
    logic [7:0] ea_wd;
    logic       ea_we;
    @(negedge clk);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      chk("cpu_rvalid", 16'(cpu_rvalid), 16'(e.cv));
      chk("aux_rvalid", 16'(aux_rvalid), 16'(e.av));
      if (e.cv) chk("cpu_rdata", 16'(cpu_rdata), 16'(e.d));
      if (e.av) chk("aux_rdata", 16'(aux_rdata), 16'(e.d));
      chk("owner", 16'(owner), 16'(e.own));
    end
    chk("cpu_gnt", 16'(cpu_gnt), 16'(ec));
    chk("aux_gnt", 16'(aux_gnt), 16'(ea));
    ea_addr = ec ? cpu_addr  : (ea ? aux_addr  : 10'h0);
    ea_wd   = ec ? cpu_wdata : (ea ? aux_wdata : 8'h0);
    ea_we   = ec ? cpu_we    : aux_we;
    chk("mem_read_en", 16'(mem_read_en), 16'((ec | ea) & ~ea_we));
    chk("mem_wr_en",   16'(mem_wr_en),   16'((ec | ea) & ea_we));
    chk("mem_addr",    16'(mem_addr),    16'(ea_addr));
    chk("mem_wdata",   16'(mem_wdata),   16'(ea_wd));
    n.cv  = ec & ~cpu_we & ~rst_at_edge & ~rst;
    n.av  = ea & ~aux_we & ~rst_at_edge & ~rst;
    n.d   = rd_fn(ea_addr);
    n.own = (rst_at_edge | rst) ? 2'b00 : (ec ? 2'b01 : (ea ? 2'b10 : 2'b00));
    q.push_back(n);
    if (rst_at_edge) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t init_e;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3F5; cpu_wdata = 8'h00;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 10'h0AA; aux_wdata = 8'h00;
    @(posedge clk);
    #1;
    init_e = '0;
    q.push_back(init_e);

    // Reset held 2 cycles with both requesting: nothing granted.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    // First cycle after release: CPU wins (counter cleared), read of 0x3F5.
    tick(1'b1, 1'b0, 1'b0);
    cpu_req = 1'b0; aux_req = 1'b0;
    tick(1'b0, 1'b0, 1'b0);          // cpu_rvalid with 0xA5, owner 01

    // Aux-only write of 0x5A to 0x100.
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 10'h100; aux_wdata = 8'h5A;
    tick(1'b0, 1'b1, 1'b0);
    aux_req = 1'b0; aux_we = 1'b0;
    tick(1'b0, 1'b0, 1'b0);          // no rvalid, owner 10
    tick(1'b0, 1'b0, 1'b0);          // owner back to 00

    // Continuous contention: C,C,C,C,A repeating over 20 cycles.
    cpu_req = 1'b1; cpu_addr = 10'h200;
    aux_req = 1'b1; aux_addr = 10'h300;
    for (int i = 0; i < 20; i++) begin
      tick((i % 5) != 4, (i % 5) == 4, 1'b0);
      if ((i % 5) != 4) cpu_addr = cpu_addr + 10'd3;
      else aux_addr = aux_addr + 10'd7;
    end
    cpu_req = 1'b0; aux_req = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    // CPU read 0x010 then aux read 0x020: consecutive, correctly tagged returns.
    cpu_req = 1'b1; cpu_addr = 10'h010;
    tick(1'b1, 1'b0, 1'b0);
    cpu_req = 1'b0;
    aux_req = 1'b1; aux_addr = 10'h020;
    tick(1'b0, 1'b1, 1'b0);
    aux_req = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    // Aux drops while starved: counter clears, CPU wins again on return.
    cpu_req = 1'b1; cpu_addr = 10'h040; aux_req = 1'b1; aux_addr = 10'h080;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    aux_req = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    aux_req = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    cpu_req = 1'b0; aux_req = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    // CPU read granted, reset sampled at the end of that cycle: no rvalid.
    cpu_req = 1'b1; cpu_addr = 10'h055;
    tick(1'b1, 1'b0, 1'b1);
    cpu_req = 1'b0;
    tick(1'b0, 1'b0, 1'b0);          // rst high: rvalid cleared, owner 00
    rst = 1'b0;
    aux_req = 1'b1; aux_addr = 10'h066;
    tick(1'b0, 1'b1, 1'b0);          // aux granted immediately
    cpu_req = 1'b1; cpu_addr = 10'h077;
    tick(1'b1, 1'b0, 1'b0);          // counter is 0: CPU wins
    cpu_req = 1'b0; aux_req = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
